fp_subtractor_seq: RTL
======================

# fp_subtractor_seq

Multi-cycle floating-point subtractor computing A − B on the team's 12-bit format: 1 sign, 3-bit unsigned exponent, 8-bit mantissa with explicit leading one. Value is (−1)^s × (m/128) × 2^e. It is the inverse operation to the combinational adder in the arithmetic datapath. It sits between operand staging and the result writeback, with valid/ready handshakes on both sides and a state machine for align, subtract and normalize.

## Interface
- No parameters; format widths are fixed at 8-bit mantissa and 3-bit exponent.
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operands present
- in_ready  out  1  block idle and able to accept operands
- operand_a_mantissa / operand_b_mantissa  in  8  mantissas; bit 7 = 1 for normalized nonzero values, 0x00 = zero
- operand_a_exponent / operand_b_exponent  in  3  exponents, 0–7
- operand_a_sign / operand_b_sign  in  1  signs, 1 = negative
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer accepts the result
- result_mantissa  out  8
- result_exponent  out  3
- result_sign  out  1
- overflow  out  1  result saturated; valid while out_valid = 1

## Operation
- Computes A + (−B): the effective B sign is ~operand_b_sign.
  - Equal effective signs → magnitude add.
  - Different effective signs → magnitude subtract.
- States and transitions:
  - IDLE → ALIGN → SUB → NORM (repeats) → [ROUND] → OUT → IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture all operands and go to ALIGN.
- ALIGN (1 cycle):
  - Order operands by magnitude, comparing {exponent, mantissa}; the larger becomes L and the smaller S.
  - Shift S right by (eL − eS) into an 11-bit field: 8 bits plus guard, round and sticky bits. The sticky bit is the OR of all bits shifted out.
- SUB (1 cycle):
  - Compute the 12-bit L ± S, including the carry bit.
  - Result sign = sign of L. If |A| = |B|, L is A.
  - Result exponent starts at eL.
- NORM (≥1 cycle, one shift per cycle):
  - Carry set: shift right 1 (sticky accumulates) and exponent +1. If the exponent was 7, saturate to mantissa 0xFF, exponent 7, overflow = 1, and go to OUT.
  - Else, if mantissa bit 7 = 0, exponent > 0 and the result is nonzero: shift left 1 and exponent −1.
  - Else leave NORM.
  - Exponent 0 with bit 7 = 0 is emitted as a denormal.
- Zero result: mantissa 0x00, exponent 0, sign 0, overflow 0.
- OUT:
  - out_valid = 1; outputs are held stable until out_ready = 1.
  - Return to IDLE on that cycle.
  - No new operand is accepted while the block is in OUT.
- Rounding policy: see Configuration.

## Timing
- Reset values (rst_n = 0 sampled on a clock edge):
  - State IDLE, in_ready = 1, out_valid = 0.
  - result_mantissa = 0x00, result_exponent = 0, result_sign = 0, overflow = 0.
- Reset mid-operation abandons the operation. The cycle after the reset edge shows the reset values; no partial result is ever presented.
- Latency, counted as clock edges from the accepting edge to the first cycle with out_valid = 1:
  - 4 when NORM takes one cycle.
  - +1 per additional left shift; worst case 11 (7 shifts).
  - +1 when rounding is compiled in (ROUND state).
- in_ready = 0 in every state except IDLE.
- Throughput: one operation in flight.
- Simultaneous out_valid & out_ready & in_valid:
  - The result is retired and the block enters IDLE.
  - New operands are accepted on the following edge, not the same one.
- Result fields and overflow change only on the edge entering OUT and on reset.

## Configuration
- FP_SUB_ROUND_EN
  - Defined: round-to-nearest-even using guard, round and sticky, in an extra ROUND cycle after NORM.
    - If rounding carries out (mantissa 0x100), the mantissa becomes 0x80 and the exponent +1.
    - If rounding carries out at exponent 7, saturate to 0xFF/7 with overflow = 1.
  - Undefined: truncation; guard, round and sticky are discarded; no ROUND state.

## Test plan
- A = (0xC0, e3, +), B = (0x80, e2, +) → result 0x80, e3, +; overflow 0; out_valid 4 edges after accept (truncation build).
- A = (0x80, e0, +), B = (0x80, e0, −) → effective add with carry → 0x80, e1, +.
- A = (0xA5, e4, −), B = (0xA5, e4, −) → exact zero: 0x00, e0, sign 0.
- A = (0xFF, e7, +), B = (0xFF, e7, −) → 0xFF, e7, +, overflow = 1.
- A = (0x81, e5, +), B = (0x80, e5, +) → 0x01 shifted left 5 times, exponent floored at 0 → 0x20, e0, +; latency 9.
- Backpressure and reset:
  - Hold out_ready = 0 for 10 cycles → outputs stable and in_ready = 0 throughout.
  - Separately, drive rst_n = 0 during NORM → next cycle out_valid = 0, in_ready = 1, all outputs 0.

Source files
------------

// File: rtl/fp_subtractor_seq.sv
// fp_subtractor_seq: multi-cycle A - B on the 12-bit float format
// (1 sign, 3-bit exponent, 8-bit mantissa with explicit leading one).
// Sequence: IDLE -> ALIGN -> SUB -> NORM (one shift per cycle) -> [ROUND] -> OUT.
// Build option: define FP_SUB_ROUND_EN for round-to-nearest-even in an extra
// ROUND cycle; left undefined the result is truncated.
module fp_subtractor_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] operand_a_mantissa,
  input  logic [2:0] operand_a_exponent,
  input  logic       operand_a_sign,
  input  logic [7:0] operand_b_mantissa,
  input  logic [2:0] operand_b_exponent,
  input  logic       operand_b_sign,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result_mantissa,
  output logic [2:0] result_exponent,
  output logic       result_sign,
  output logic       overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_SUB, S_NORM, S_ROUND, S_OUT
  } state_t;

  state_t      state_q, state_d;
  // captured operands; b_s holds the effective (inverted) B sign
  logic [7:0]  a_m_q, a_m_d, b_m_q, b_m_d;
  logic [2:0]  a_e_q, a_e_d, b_e_q, b_e_d;
  logic        a_s_q, a_s_d, b_s_q, b_s_d;
  // larger operand L and aligned smaller operand S (8 bits + G/R/sticky)
  logic [7:0]  lm_q, lm_d;
  logic [2:0]  le_q, le_d;
  logic        ls_q, ls_d;
  logic [10:0] sf_q, sf_d;
  logic        sub_q, sub_d;
  // working sum: [11] carry, [10:3] mantissa, [2:0] guard/round/sticky
  logic [11:0] acc_q, acc_d;
  logic [2:0]  ex_q, ex_d;
  logic        sg_q, sg_d;
  // result registers, written only on the edge entering OUT
  logic [7:0]  res_m_q, res_m_d;
  logic [2:0]  res_e_q, res_e_d;
  logic        res_s_q, res_s_d, ovf_q, ovf_d;

  // alignment scratch
  logic [7:0]  sm;
  logic [2:0]  se, shamt;
  logic [18:0] wide;
`ifdef FP_SUB_ROUND_EN
  logic        rnd_up;
  logic [8:0]  m9;
`endif

  assign in_ready        = (state_q == S_IDLE);
  assign out_valid       = (state_q == S_OUT);
  assign result_mantissa = res_m_q;
  assign result_exponent = res_e_q;
  assign result_sign     = res_s_q;
  assign overflow        = ovf_q;

  // register bank: state, datapath and results, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_m_q <= '0; a_e_q <= '0; a_s_q <= 1'b0;
      b_m_q <= '0; b_e_q <= '0; b_s_q <= 1'b0;
      lm_q <= '0; le_q <= '0; ls_q <= 1'b0; sf_q <= '0; sub_q <= 1'b0;
      acc_q <= '0; ex_q <= '0; sg_q <= 1'b0;
      res_m_q <= '0; res_e_q <= '0; res_s_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_m_q <= a_m_d; a_e_q <= a_e_d; a_s_q <= a_s_d;
      b_m_q <= b_m_d; b_e_q <= b_e_d; b_s_q <= b_s_d;
      lm_q <= lm_d; le_q <= le_d; ls_q <= ls_d; sf_q <= sf_d; sub_q <= sub_d;
      acc_q <= acc_d; ex_q <= ex_d; sg_q <= sg_d;
      res_m_q <= res_m_d; res_e_q <= res_e_d; res_s_q <= res_s_d; ovf_q <= ovf_d;
    end
  end

  // next-state and datapath update per state
  always_comb begin
    state_d = state_q;
    a_m_d = a_m_q; a_e_d = a_e_q; a_s_d = a_s_q;
    b_m_d = b_m_q; b_e_d = b_e_q; b_s_d = b_s_q;
    lm_d = lm_q; le_d = le_q; ls_d = ls_q; sf_d = sf_q; sub_d = sub_q;
    acc_d = acc_q; ex_d = ex_q; sg_d = sg_q;
    res_m_d = res_m_q; res_e_d = res_e_q; res_s_d = res_s_q; ovf_d = ovf_q;
    sm = '0; se = '0; shamt = '0; wide = '0;
`ifdef FP_SUB_ROUND_EN
    rnd_up = 1'b0; m9 = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_m_d = operand_a_mantissa; a_e_d = operand_a_exponent; a_s_d = operand_a_sign;
          b_m_d = operand_b_mantissa; b_e_d = operand_b_exponent; b_s_d = ~operand_b_sign;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        // ties keep A as L so |A| = |B| takes A's sign
        if ({a_e_q, a_m_q} >= {b_e_q, b_m_q}) begin
          lm_d = a_m_q; le_d = a_e_q; ls_d = a_s_q; sm = b_m_q; se = b_e_q;
        end else begin
          lm_d = b_m_q; le_d = b_e_q; ls_d = b_s_q; sm = a_m_q; se = a_e_q;
        end
        shamt = le_d - se;
        // low 8 bits of wide catch everything shifted past the sticky slot
        wide  = {sm, 11'b0} >> shamt;
        sf_d  = {wide[18:9], wide[8] | (|wide[7:0])};
        sub_d = a_s_q ^ b_s_q;
        state_d = S_SUB;
      end
      S_SUB: begin
        if (sub_q) acc_d = {1'b0, lm_q, 3'b000} - {1'b0, sf_q};
        else       acc_d = {1'b0, lm_q, 3'b000} + {1'b0, sf_q};
        ex_d = le_q;
        sg_d = ls_q;
        state_d = S_NORM;
      end
      S_NORM: begin
        if (acc_q[11]) begin
          if (ex_q == 3'd7) begin
            res_m_d = 8'hFF; res_e_d = 3'd7; res_s_d = sg_q; ovf_d = 1'b1;
            state_d = S_OUT;
          end else begin
            acc_d = {1'b0, acc_q[11:2], acc_q[1] | acc_q[0]};
            ex_d  = ex_q + 3'd1;
          end
        end else if (!acc_q[10] && ex_q != 3'd0 && acc_q != 12'd0) begin
          acc_d = {acc_q[10:0], 1'b0};
          ex_d  = ex_q - 3'd1;
        end else begin
`ifdef FP_SUB_ROUND_EN
          state_d = S_ROUND;
`else
          // truncation: a zero mantissa is reported as canonical +0
          if (acc_q[10:3] == 8'd0) begin
            res_m_d = 8'd0; res_e_d = 3'd0; res_s_d = 1'b0;
          end else begin
            res_m_d = acc_q[10:3]; res_e_d = ex_q; res_s_d = sg_q;
          end
          ovf_d = 1'b0;
          state_d = S_OUT;
`endif
        end
      end
`ifdef FP_SUB_ROUND_EN
      S_ROUND: begin
        // nearest-even: round up on G and (R or sticky or LSB)
        rnd_up = acc_q[2] & (acc_q[1] | acc_q[0] | acc_q[3]);
        m9 = {1'b0, acc_q[10:3]} + {8'd0, rnd_up};
        ovf_d = 1'b0;
        if (m9[8]) begin
          if (ex_q == 3'd7) begin
            res_m_d = 8'hFF; res_e_d = 3'd7; ovf_d = 1'b1;
          end else begin
            res_m_d = 8'h80; res_e_d = ex_q + 3'd1;
          end
          res_s_d = sg_q;
        end else if (m9[7:0] == 8'd0) begin
          res_m_d = 8'd0; res_e_d = 3'd0; res_s_d = 1'b0;
        end else begin
          res_m_d = m9[7:0]; res_e_d = ex_q; res_s_d = sg_q;
        end
        state_d = S_OUT;
      end
`endif
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
